// File: rtl/arb8_rr_encoder.sv
// arb8_rr_encoder: eight-requester round-robin arbiter with one-hot and
// binary grant outputs and an optional hold timeout. A requester keeps the
// grant until it drops its request or MAX_HOLD cycles elapse. After every
// grant the resource is idle for at least one cycle before the next owner.
module arb8_rr_encoder #(
    parameter int MAX_HOLD = 16 // 0..255, 0 disables the timeout
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    localparam bit         HOLD_EN    = (MAX_HOLD != 0);

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic       timeout_q, timeout_d;
    logic [2:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    logic       found;
    logic [2:0] win;
    logic [2:0] cand;

    // Round-robin search: first set request starting just above the last winner.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        cand  = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            // 3-bit wrap makes the search circular; k=8 lands on last_q itself.
            cand = last_q + 3'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        last_d    = last_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d   = 8'h00;
                valid_d = 1'b0;
                if (en && found) begin
                    gnt_d   = 8'b1 << win;
                    idx_d   = win;
                    valid_d = 1'b1;
                    last_d  = win;
                    cnt_d   = 8'd1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    // Normal release wins over a coinciding timeout.
                    gnt_d   = 8'h00;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (HOLD_EN && (cnt_q == MAX_HOLD_C)) begin
                    // Forced release; last_q already holds this owner's index,
                    // so it drops to lowest priority for the next search.
                    gnt_d     = 8'h00;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                gnt_d   = 8'h00;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q   <= IDLE;
            gnt_q     <= 8'h00;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            last_q    <= 3'd7;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/arb8_rr_encoder.md
# arb8_rr_encoder

Eight-requester round-robin arbiter for a shared single-owner resource. Each cycle in which the resource is free, it picks one of up to eight pending requests. It drives both a one-hot grant and its 3-bit encoded index, as used by the 8-to-3 encoding path. It holds the grant until the owner releases it or a hold timeout expires.

## Interface
- MAX_HOLD, 16, maximum grant length in clock cycles; legal range 0..255; 0 disables the timeout.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- en  input  1  arbitration enable; low blocks new grants but does not revoke the current one.
- req  input  8  request lines; requester i holds req[i] high for as long as it wants or keeps the grant.
- gnt  output  8  one-hot grant, registered; all-zero when no owner.
- gnt_idx  output  3  binary index of the owner, registered; valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is held; equals OR of gnt.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

## Operation
- Reset values:
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - state=IDLE, hold counter=0, last winner register last=7, so index 0 has top priority after reset.
- States: IDLE, GRANT.
- IDLE, when en=1 and req!=0:
  - Winner = first set req[i] searching from (last+1) mod 8 upward, wrapping 7->0.
  - Next edge: gnt=1<<winner, gnt_idx=winner, gnt_valid=1, last=winner, counter=1, state=GRANT.
- IDLE, when en=0 or req=0: outputs stay zero and state stays IDLE.
- GRANT, normal release: req[gnt_idx]=0 at an edge -> gnt cleared, state=IDLE at that edge.
- GRANT, forced release: MAX_HOLD!=0 and counter==MAX_HOLD at an edge while req[gnt_idx]=1:
  - gnt cleared, timeout=1 for exactly one cycle, state=IDLE.
  - The owner keeps lowest priority (last = its index).
- GRANT, otherwise: counter increments (8-bit, saturating at 255) and the grant holds.
- Requests from non-owners during GRANT are ignored, not queued. They are re-evaluated in IDLE.
- Simultaneous release and timeout at the same edge: treat as normal release, timeout=0.
- en falling during GRANT has no effect on the current owner. en is sampled only in IDLE.
- gnt_idx retains its last value while gnt_valid=0. The bench checks gnt_idx only when gnt_valid=1.

## Timing
- Request to grant latency:
  - req rising before edge k with the arbiter in IDLE -> gnt visible after edge k.
  - Minimum latency is 1 cycle.
- Release latency: req[owner] low before edge m -> gnt=0 after edge m.
- Re-arbitration: IDLE lasts at least one cycle, so the earliest next grant is after edge m+1.
  - This gives a mandatory one-cycle dead gap between owners.
- Grant duration:
  - With MAX_HOLD=N>0, gnt stays high for at most N cycles.
  - timeout asserts in the cycle immediately after the last granted cycle.
- Async reset: rst_n low clears all outputs immediately, mid-grant included, with no dependence on clk. Deassertion is synchronised externally.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - When valid, gnt_idx == encode(gnt).

## Test plan
- Reset mid-grant:
  - Stimulus: req=8'h10 granted, then rst_n=0 asynchronously between edges.
  - Response: gnt=0, gnt_valid=0, timeout=0 immediately; after release, req=8'hFF grants index 0 first.
- Single requester:
  - Stimulus: req=8'h08 for 5 cycles, then 0.
  - Response: gnt=8'h08 and gnt_idx=3 one cycle after the request; gnt=0 one edge after the drop.
- Fairness with two requesters:
  - Stimulus: req=8'h81 held, each owner dropping its bit for one cycle after 2 granted cycles.
  - Response: grants alternate idx 0, 7, 0, 7 with a one-cycle gap between them.
- Full wrap:
  - Stimulus: req=8'hFF, each owner releasing after 1 cycle.
  - Response: gnt_idx sequence 0,1,2,...,7,0. gnt is never non-one-hot.
- Timeout:
  - Stimulus: MAX_HOLD=4, req=8'h24 held constantly.
  - Response:
    - idx 2 is granted for exactly 4 cycles, then a timeout pulse.
    - idx 5 is granted next, times out after 4 cycles, then idx 2 again.
- Enable gating:
  - Stimulus: en=0 with req=8'h02.
  - Response: no grant. The grant follows 1 cycle after en rises. Dropping en during GRANT keeps gnt=8'h02.
